// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor 0 block: register numbers,
// field positions inside SR/Cause, exception codes and the handler vector.
package cp0_pkg;

   localparam int CP0_ADDR_W = 5;

   // CP0 register numbers
   localparam logic [CP0_ADDR_W-1:0] CP0_SR    = 5'd12;
   localparam logic [CP0_ADDR_W-1:0] CP0_CAUSE = 5'd13;
   localparam logic [CP0_ADDR_W-1:0] CP0_EPC   = 5'd14;
   localparam logic [CP0_ADDR_W-1:0] CP0_PRID  = 5'd15;

   // Field positions in SR and Cause
   localparam int IM_HI   = 15;
   localparam int IM_LO   = 10;
   localparam int EXL_BIT = 1;
   localparam int IE_BIT  = 0;
   localparam int BD_BIT  = 31;
   localparam int EXC_HI  = 6;
   localparam int EXC_LO  = 2;

   // ExcCode values
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Fetch redirect target whenever req is taken
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_if.sv
// M-stage to CP0 bundle: mtc0/mfc0 access, exception inputs, interrupt
// lines, and the req/read-data/EPC results going back to the pipeline.
interface cp0_if
   import cp0_pkg::*;
#(
   parameter int HW_INT_W = 6
);
   logic                  we;
   logic [CP0_ADDR_W-1:0] addr;
   logic [31:0]           din;
   logic [31:0]           vpc;
   logic                  bd_in;
   logic [4:0]            exc_in;
   logic                  exl_clr;
   logic [HW_INT_W-1:0]   hw_int;
   logic                  req;
   logic [31:0]           dout;
   logic [31:0]           epc_out;

   modport master (
      output we, addr, din, vpc, bd_in, exc_in, exl_clr, hw_int,
      input  req, dout, epc_out
   );

   modport slave (
      input  we, addr, din, vpc, bd_in, exc_in, exl_clr, hw_int,
      output req, dout, epc_out
   );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: arbitrates hardware interrupts against M-stage exceptions,
// holds SR/Cause/EPC/PRId and serves mfc0 reads and the eret EPC.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VAL = 32'h4255_4141,
   parameter int          HW_INT_W = 6
) (
   input  logic clk,
   input  logic reset,
   cp0_if.slave bus
);

   // Architectural state (only the implemented fields are stored)
   logic [HW_INT_W-1:0] r_im;
   logic                r_exl;
   logic                r_ie;
   logic                r_bd;
   logic [HW_INT_W-1:0] r_ip;
   logic [4:0]          r_exc_code;
   logic [31:0]         r_epc;

   logic        w_int_req;
   logic        w_exc_req;
   logic        w_req;
   logic [31:0] w_sr;
   logic [31:0] w_cause;
   logic [31:0] w_dout;

   // EXL masks both sources, so a handler is never re-entered until eret.
   assign w_int_req = r_ie & ~r_exl & (|(bus.hw_int & r_im));
   assign w_exc_req = ~r_exl & (bus.exc_in != 5'd0);
   assign w_req     = ~reset & (w_int_req | w_exc_req);

   assign bus.req     = w_req;
   assign bus.epc_out = r_epc;
   assign bus.dout    = w_dout;

   // Assemble the SR/Cause read images and select mfc0 data (no write-through)
   always_comb begin
      w_sr                        = '0;
      w_sr[IM_LO +: HW_INT_W]     = r_im;
      w_sr[EXL_BIT]               = r_exl;
      w_sr[IE_BIT]                = r_ie;

      w_cause                     = '0;
      w_cause[BD_BIT]             = r_bd;
      w_cause[IM_LO +: HW_INT_W]  = r_ip;
      w_cause[EXC_HI:EXC_LO]      = r_exc_code;

      w_dout = '0;
      case (bus.addr)
         CP0_SR:    w_dout = w_sr;
         CP0_CAUSE: w_dout = w_cause;
         CP0_EPC:   w_dout = r_epc;
         CP0_PRID:  w_dout = PRID_VAL;
         default:   w_dout = '0;
      endcase
   end

   // Register update: taking an exception squashes the same-cycle mtc0/eret,
   // while Cause.IP tracks the interrupt lines every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ip       <= '0;
         r_exc_code <= '0;
         r_epc      <= '0;
      end else begin
         r_ip <= bus.hw_int;
         if (w_req) begin
            r_exl      <= 1'b1;
            r_exc_code <= w_int_req ? EXC_INT : bus.exc_in;
            r_bd       <= bus.bd_in;
            r_epc      <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
         end else begin
            if (bus.we && (bus.addr == CP0_SR)) begin
               r_im  <= bus.din[IM_LO +: HW_INT_W];
               r_exl <= bus.din[EXL_BIT];
               r_ie  <= bus.din[IE_BIT];
            end
            if (bus.we && (bus.addr == CP0_EPC)) begin
               r_epc <= bus.din;
            end
            // Placed after the SR write so eret wins the EXL bit.
            if (bus.exl_clr) begin
               r_exl <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit: directed vector table, a reset-while-pending
// sequence, then randomized traffic checked against a register-image model.
module tb_cp0_unit;

   localparam logic [31:0] PRID = 32'h4255_4141;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   cp0_if #(.HW_INT_W(6)) bus ();

   cp0_unit #(.PRID_VAL(PRID), .HW_INT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] din;
      logic [31:0] vpc;
      logic        bd;
      logic [4:0]  exc;
      logic        clr;
      logic [5:0]  hw;
      logic        e_req;
      logic [31:0] e_dout;
      logic [31:0] e_epc;
   } vec_t;

   vec_t tbl[22];

   // Behavioural model: full 32-bit register images
   logic [31:0] m_sr, m_cause, m_epc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [4:0] addr, input logic [31:0] din,
                               input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                               input logic clr, input logic [5:0] hw, input logic e_req,
                               input logic [31:0] e_dout, input logic [31:0] e_epc);
      vec_t v;
      v.we = we; v.addr = addr; v.din = din; v.vpc = vpc; v.bd = bd; v.exc = exc;
      v.clr = clr; v.hw = hw; v.e_req = e_req; v.e_dout = e_dout; v.e_epc = e_epc;
      return v;
   endfunction

   task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] din,
                        input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                        input logic clr, input logic [5:0] hw);
      bus.we = we; bus.addr = addr; bus.din = din; bus.vpc = vpc;
      bus.bd_in = bd; bus.exc_in = exc; bus.exl_clr = clr; bus.hw_int = hw;
   endtask

   function automatic logic [31:0] model_dout(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      logic        r_we, r_bd, r_clr, r_rst;
      logic [4:0]  r_addr, r_exc;
      logic [31:0] r_din, r_vpc;
      logic [5:0]  r_hw;
      logic        m_int, m_exc, m_req;
      logic [5:0]  m_im;

      checks = 0;
      errors = 0;

      //            we  addr  din            vpc            bd  exc    clr hw     req  dout           epc
      tbl[0]  = mk(0, 5'd12, 32'h0,         32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h0,         32'h0);
      tbl[1]  = mk(0, 5'd13, 32'h0,         32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h0,         32'h0);
      tbl[2]  = mk(0, 5'd14, 32'h0,         32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h0,         32'h0);
      tbl[3]  = mk(0, 5'd15, 32'h0,         32'h0,         0, 5'd0,  0, 6'h00, 0, PRID,          32'h0);
      tbl[4]  = mk(1, 5'd12, 32'h0000_0401, 32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h0,         32'h0);
      tbl[5]  = mk(0, 5'd12, 32'h0,         32'h0000_3010, 0, 5'd0,  0, 6'h01, 1, 32'h0000_0401, 32'h0);
      tbl[6]  = mk(0, 5'd12, 32'h0,         32'h0000_3014, 0, 5'd0,  0, 6'h01, 0, 32'h0000_0403, 32'h0000_3010);
      tbl[7]  = mk(0, 5'd13, 32'h0,         32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h0000_0400, 32'h0000_3010);
      tbl[8]  = mk(0, 5'd14, 32'h0,         32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h0000_3010, 32'h0000_3010);
      tbl[9]  = mk(0, 5'd12, 32'h0,         32'h0,         0, 5'd0,  1, 6'h00, 0, 32'h0000_0403, 32'h0000_3010);
      tbl[10] = mk(1, 5'd14, 32'hDEAD_BEEF, 32'h0000_3024, 1, 5'd12, 0, 6'h00, 1, 32'h0000_3010, 32'h0000_3010);
      tbl[11] = mk(0, 5'd14, 32'h0,         32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h0000_3020, 32'h0000_3020);
      tbl[12] = mk(0, 5'd13, 32'h0,         32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h8000_0030, 32'h0000_3020);
      tbl[13] = mk(0, 5'd12, 32'h0,         32'h0,         0, 5'd0,  1, 6'h00, 0, 32'h0000_0403, 32'h0000_3020);
      tbl[14] = mk(1, 5'd12, 32'h0000_1001, 32'h0,         0, 5'd0,  0, 6'h00, 0, 32'h0000_0401, 32'h0000_3020);
      tbl[15] = mk(0, 5'd13, 32'h0,         32'h0000_3040, 0, 5'd4,  0, 6'h04, 1, 32'h8000_0030, 32'h0000_3020);
      tbl[16] = mk(0, 5'd13, 32'h0,         32'h0000_3044, 0, 5'd5,  0, 6'h04, 0, 32'h0000_1000, 32'h0000_3040);
      tbl[17] = mk(0, 5'd14, 32'h0,         32'h0000_3050, 0, 5'd5,  0, 6'h04, 0, 32'h0000_3040, 32'h0000_3040);
      tbl[18] = mk(0, 5'd12, 32'h0,         32'h0,         0, 5'd0,  1, 6'h04, 0, 32'h0000_1003, 32'h0000_3040);
      tbl[19] = mk(0, 5'd12, 32'h0,         32'h0000_3060, 0, 5'd0,  0, 6'h04, 1, 32'h0000_1001, 32'h0000_3040);
      tbl[20] = mk(0, 5'd14, 32'h0,         32'h0,         0, 5'd0,  0, 6'h04, 0, 32'h0000_3060, 32'h0000_3060);
      tbl[21] = mk(0, 5'd12, 32'h0,         32'h0,         0, 5'd0,  1, 6'h04, 0, 32'h0000_1003, 32'h0000_3060);

      // Reset with every interrupt line high: req must stay low
      reset = 1'b1;
      drive(0, 5'd12, 32'h0, 32'h0, 0, 5'd0, 0, 6'h3F);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("reset_req_%0d", i), {31'b0, bus.req}, 32'h0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(0, 5'd12, 32'h0, 32'h0, 0, 5'd0, 0, 6'h00);

      // Directed vectors
      for (int i = 0; i < 22; i++) begin
         @(posedge clk);
         #1;
         drive(tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].vpc, tbl[i].bd,
               tbl[i].exc, tbl[i].clr, tbl[i].hw);
         @(negedge clk);
         $display("vec %0d addr=%0d req=%0b dout=%h epc=%h", i, bus.addr, bus.req, bus.dout, bus.epc_out);
         chk($sformatf("vec%0d_req", i),  {31'b0, bus.req}, {31'b0, tbl[i].e_req});
         chk($sformatf("vec%0d_dout", i), bus.dout,         tbl[i].e_dout);
         chk($sformatf("vec%0d_epc", i),  bus.epc_out,      tbl[i].e_epc);
      end

      // Reset while an enabled interrupt is pending
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(0, 5'd12, 32'h0, 32'h0000_3070, 0, 5'd0, 0, 6'h04);
      @(negedge clk);
      $display("reset pending req=%0b dout=%h", bus.req, bus.dout);
      chk("rst_pending_req", {31'b0, bus.req}, 32'h0);
      chk("rst_pending_dout", bus.dout, 32'h0000_1001);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(0, 5'd12, 32'h0, 32'h0, 0, 5'd0, 0, 6'h00);
      for (int a = 12; a < 15; a++) begin
         bus.addr = 5'(a);
         #1;
         $display("post reset addr=%0d dout=%h", a, bus.dout);
         chk($sformatf("post_rst_reg%0d", a), bus.dout, 32'h0);
         @(posedge clk);
         #1;
      end

      // Randomized traffic against the register-image model
      m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         #1;
         r_rst  = ($urandom_range(0, 39) == 0);
         r_we   = ($urandom_range(0, 1) == 1);
         r_addr = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
         r_din  = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h1) : $urandom;
         r_vpc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         r_bd   = ($urandom_range(0, 1) == 1);
         r_exc  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
         r_clr  = ($urandom_range(0, 4) == 0);
         r_hw   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
         reset  = r_rst;
         drive(r_we, r_addr, r_din, r_vpc, r_bd, r_exc, r_clr, r_hw);

         m_im  = m_sr[15:10];
         m_int = m_sr[0] && !m_sr[1] && ((r_hw & m_im) != 6'h0);
         m_exc = !m_sr[1] && (r_exc != 5'd0);
         m_req = !r_rst && (m_int || m_exc);

         @(negedge clk);
         $display("rnd %0d rst=%0b we=%0b addr=%0d exc=%0d hw=%h req=%0b dout=%h epc=%h",
                  n, r_rst, r_we, r_addr, r_exc, r_hw, bus.req, bus.dout, bus.epc_out);
         chk($sformatf("rnd%0d_req", n),  {31'b0, bus.req}, {31'b0, m_req});
         chk($sformatf("rnd%0d_dout", n), bus.dout,         model_dout(r_addr));
         chk($sformatf("rnd%0d_epc", n),  bus.epc_out,      m_epc);

         // Advance the model across the coming edge
         if (r_rst) begin
            m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
         end else begin
            m_cause[15:10] = r_hw;
            if (m_req) begin
               m_sr[1]       = 1'b1;
               m_cause[6:2]  = m_int ? 5'd0 : r_exc;
               m_cause[31]   = r_bd;
               m_epc         = r_bd ? r_vpc - 32'd4 : r_vpc;
            end else begin
               if (r_we && r_addr == 5'd12) m_sr = r_din & 32'h0000_FC03;
               if (r_we && r_addr == 5'd14) m_epc = r_din;
               if (r_clr) m_sr[1] = 1'b0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
